conv_encoder: RTL and testbench

//  Rate-1/r, constraint-length-K convolutional encoder; upstream stage of the viterbi decoder.

---
 rtl/conv_encoder.sv | 121 ++++++++++++
 tb/tb_conv_encoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder.sv
// Rate-1/r, constraint-length-K convolutional encoder feeding the viterbi decoder.
// One data bit per clock from state 0; codeword held on codeout until acknowledged.
module conv_encoder #(
  parameter int r      = 2,
  parameter int K      = 3,
  parameter int lenout = 5,
  parameter int lenin  = 10,
  parameter logic [r*K-1:0] G = 6'b111_101
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [lenout-1:0]             data_in,
  output logic                          ready,
  output logic                          code_valid,
  input  logic                          code_ack,
  output logic [lenin-1:0]              codeout,
  output logic [(1<<(K-1))*2*r-1:0]     state_table
);

  localparam int NSTATE = 1 << (K-1);
  localparam int CW     = $clog2(lenout + 1);
  localparam logic [CW-1:0] LAST = CW'(lenout - 1);

  if (lenin != r*lenout) begin : g_len_check
    $error("conv_encoder: lenin must equal r*lenout");
  end

  typedef enum logic [1:0] {IDLE, ENC, DONE} state_e;

  // Tap vector is {u, s[0], ..., s[K-2]} against g[K-1:0]; generator i drives symbol bit i.
  function automatic logic [r-1:0] enc_sym(input logic [K-2:0] s, input logic u);
    logic [K-1:0] tap;
    logic [r-1:0] sym;
    tap[K-1] = u;
    for (int k = 0; k < K-1; k++) tap[K-2-k] = s[k];
    for (int i = 0; i < r; i++) sym[i] = ^(G[i*K +: K] & tap);
    return sym;
  endfunction

  state_e              state_q;
  logic                ready_q, code_valid_q;
  logic [lenin-1:0]    codeout_q, cw_q, cw_d;
  logic [lenout-1:0]   data_q;
  logic [K-2:0]        s_q, s_d;
  logic [CW-1:0]       cnt_q;
  logic                u;
  logic [r-1:0]        sym;
  logic [K-1:0]        s_ext;
  logic [lenin+r-1:0]  cw_ext;

  always_comb begin
    u      = data_q[lenout-1];
    sym    = enc_sym(s_q, u);
    s_ext  = {s_q, u};
    s_d    = s_ext[K-2:0];
    cw_ext = {cw_q, sym};
    cw_d   = cw_ext[lenin-1:0];
  end

  always_comb begin
    state_table = '0;
    for (int j = 0; j < NSTATE*2; j++) begin
      state_table[j*r +: r] = enc_sym((K-1)'(j >> 1), j[0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      code_valid_q <= 1'b0;
      codeout_q    <= '0;
      cw_q         <= '0;
      data_q       <= '0;
      s_q          <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            data_q  <= data_in;
            s_q     <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= ENC;
          end
        end
        ENC: begin
          data_q <= data_q << 1;
          s_q    <= s_d;
          cw_q   <= cw_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            codeout_q    <= cw_d;
            code_valid_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          // start is deliberately ignored here; only ack moves us on.
          if (code_ack) begin
            code_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q      <= IDLE;
          ready_q      <= 1'b1;
          code_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready      = ready_q;
  assign code_valid = code_valid_q;
  assign codeout    = codeout_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder with default parameters (r=2, K=3, G=111_101).
module tb_conv_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  data_in = '0;
  logic        ready;
  logic        code_valid;
  logic        code_ack = 1'b0;
  logic [9:0]  codeout;
  logic [15:0] state_table;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_encoder dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .ready(ready),
    .code_valid(code_valid), .code_ack(code_ack), .codeout(codeout),
    .state_table(state_table)
  );

  // Hand-derived equations for G=111_101: msb = u^s0^s1, lsb = u^s1.
  function automatic logic [9:0] ref_enc(input logic [4:0] d);
    logic s0, s1, u;
    logic [9:0] cw;
    s0 = 0; s1 = 0; cw = '0;
    for (int i = 4; i >= 0; i--) begin
      u  = d[i];
      cw = {cw[7:0], u ^ s0 ^ s1, u ^ s1};
      s1 = s0;
      s0 = u;
    end
    return cw;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", code_valid); end
    checks++; if (codeout !== 10'd0) begin errors++; $display("FAIL reset_codeout got=%b exp=0", codeout); end
    checks++; if (state_table !== 16'b1001001101101100) begin
      errors++; $display("FAIL state_table got=%b exp=1001001101101100", state_table);
    end
  endtask

  task automatic test_basic;
    data_in = 5'b10110;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    data_in = 5'b00000;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL basic_busy got=%b exp=0", ready); end
    repeat (4) tick();
    checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", code_valid); end
    tick();
    checks++; if (code_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", code_valid); end
    checks++; if (codeout !== 10'b11_10_00_01_01) begin
      errors++; $display("FAIL basic_codeout got=%b exp=1110000101", codeout);
    end
    code_ack = 1'b1;
    tick();
    code_ack = 1'b0;
    checks++; if (ready !== 1'b1 || code_valid !== 1'b0) begin
      errors++; $display("FAIL basic_ack ready=%b valid=%b exp ready=1 valid=0", ready, code_valid);
    end
    checks++; if (codeout !== 10'b11_10_00_01_01) begin
      errors++; $display("FAIL basic_codeout_kept got=%b exp=1110000101", codeout);
    end
  endtask

  task automatic test_patterns;
    logic [4:0] din [3];
    logic [9:0] exp [3];
    int n;
    din[0] = 5'b00000; exp[0] = 10'b00_00_00_00_00;
    din[1] = 5'b11111; exp[1] = 10'b11_01_10_10_10;
    din[2] = 5'b01001; exp[2] = 10'b00_11_10_11_11;
    for (int p = 0; p < 3; p++) begin
      data_in = din[p];
      start   = 1'b1;
      tick();
      start   = 1'b0;
      n = 1;
      while (!code_valid && n < 20) begin tick(); n++; end
      checks++; if (n != 6) begin errors++; $display("FAIL pattern%0d_latency got=%0d exp=6", p, n); end
      checks++; if (codeout !== exp[p]) begin
        errors++; $display("FAIL pattern%0d_codeout got=%b exp=%b", p, codeout, exp[p]);
      end
      code_ack = 1'b1;
      tick();
      code_ack = 1'b0;
    end
  endtask

  task automatic test_hold;
    int bad;
    data_in = 5'b11001;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    repeat (5) tick();
    checks++; if (code_valid !== 1'b1 || codeout !== 10'b11_01_01_11_11) begin
      errors++; $display("FAIL hold_first valid=%b codeout=%b exp valid=1 codeout=1101011111", code_valid, codeout);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      start   = (c == 10);
      data_in = (c == 10) ? 5'b00000 : 5'b11001;
      tick();
      if (code_valid !== 1'b1 || ready !== 1'b0 || codeout !== 10'b11_01_01_11_11) bad++;
    end
    start = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable bad_cycles=%0d exp=0", bad); end
    code_ack = 1'b1;
    start    = 1'b1;
    data_in  = 5'b11111;
    tick();
    start    = 1'b0;
    checks++; if (ready !== 1'b1 || code_valid !== 1'b0) begin
      errors++; $display("FAIL hold_ack ready=%b valid=%b exp ready=1 valid=0", ready, code_valid);
    end
    tick();
    code_ack = 1'b0;
    checks++; if (ready !== 1'b1 || code_valid !== 1'b0) begin
      errors++; $display("FAIL idle_ack_ignored ready=%b valid=%b exp ready=1 valid=0", ready, code_valid);
    end
  endtask

  task automatic test_reset_mid;
    data_in = 5'b11111;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (ready !== 1'b1 || code_valid !== 1'b0 || codeout !== 10'd0) begin
      errors++; $display("FAIL reset_mid ready=%b valid=%b codeout=%b exp 1 0 0", ready, code_valid, codeout);
    end
    data_in = 5'b10110;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    repeat (5) tick();
    checks++; if (code_valid !== 1'b1 || codeout !== 10'b11_10_00_01_01) begin
      errors++; $display("FAIL reset_mid_after valid=%b codeout=%b exp 1 1110000101", code_valid, codeout);
    end
    code_ack = 1'b1;
    tick();
    code_ack = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [4:0] blk [4];
    logic [9:0] exp_q [$];
    logic [9:0] e;
    int k, got, last;
    blk[0] = 5'b10110; blk[1] = 5'b01101; blk[2] = 5'b11100; blk[3] = 5'b00011;
    k = 0; got = 0; last = -1;
    code_ack = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
      if (ready && k < 4) begin
        start   = 1'b1;
        data_in = blk[k];
        exp_q.push_back(ref_enc(blk[k]));
        k++;
      end else begin
        start   = (k < 4);
        data_in = 5'($urandom);
      end
      tick();
      if (code_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'bx;
        checks++; if (codeout !== e) begin
          errors++; $display("FAIL b2b_codeout%0d got=%b exp=%b", got, codeout, e);
        end
        if (last >= 0) begin
          checks++; if (cyc - last != 7) begin
            errors++; $display("FAIL b2b_interval%0d got=%0d exp=7", got, cyc - last);
          end
        end
        last = cyc;
        got++;
      end
    end
    checks++; if (got != 4) begin errors++; $display("FAIL b2b_timeout blocks=%0d exp=4", got); end
    start    = 1'b0;
    code_ack = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
